enc_8b10b_rd_sel: RTL and testbench

ENC_8B10B_RD_SEL -- requirements
Module: enc_8b10b_rd_sel

---
 rtl/enc_8b10b_rd_sel.sv | 84 ++++++++
 tb/tb_enc_8b10b_rd_sel.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/enc_8b10b_rd_sel.sv
// 8b/10b codeword selector: picks the RD-matched table word, tracks running
// disparity, flags illegal-weight / control-word errors and counts them.
module enc_8b10b_rd_sel #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [9:0]       i_minus,
  input  logic [9:0]       i_plus,
  input  logic             i_k_error,
  input  logic             i_rd_reset,
  input  logic             i_cnt_clr,
  output logic [9:0]       o_data,
  output logic             o_valid,
  output logic             o_rd,
  output logic             o_disp_error,
  output logic             o_k_error,
  output logic [CNT_W-1:0] o_err_cnt
);

  logic [9:0]       r_data;
  logic             r_valid;
  logic             r_rd;
  logic             r_disp_error;
  logic             r_k_error;
  logic [CNT_W-1:0] r_err_cnt;

  logic       w_eff_rd;
  logic [9:0] w_sel;
  logic [3:0] w_weight;
  logic       w_flip;
  logic       w_disp_error;
  logic       w_k_error;
  logic       w_err;
  logic       w_next_rd;

  always_comb begin
    w_eff_rd = i_rd_reset ? 1'b0 : r_rd;
    w_sel    = w_eff_rd ? i_plus : i_minus;
    w_weight = '0;
    for (int unsigned b = 0; b < 10; b++) begin
      w_weight = w_weight + 4'(w_sel[b]);
    end
    // Only a +2 word from RD- or a -2 word from RD+ moves the disparity.
    w_flip       = ((w_weight == 4'd6) && !w_eff_rd) || ((w_weight == 4'd4) && w_eff_rd);
    w_k_error    = i_valid && i_k_error;
    w_disp_error = i_valid && !i_k_error && !w_flip && (w_weight != 4'd5);
    w_err        = w_disp_error || w_k_error;
    w_next_rd    = (i_valid && !i_k_error && w_flip) ? ~w_eff_rd : w_eff_rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_rd         <= 1'b0;
      r_disp_error <= 1'b0;
      r_k_error    <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_valid      <= i_valid;
      r_disp_error <= w_disp_error;
      r_k_error    <= w_k_error;
      r_rd         <= w_next_rd;
      if (i_valid) begin
        r_data <= i_k_error ? '0 : w_sel;
      end
      if (i_cnt_clr) begin
        r_err_cnt <= w_err ? CNT_W'(1) : '0;
      end else if (w_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_rd         = r_rd;
  assign o_disp_error = r_disp_error;
  assign o_k_error    = r_k_error;
  assign o_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_enc_8b10b_rd_sel.sv
// Bench for enc_8b10b_rd_sel: a disparity-rule model checked every cycle on
// two instances (default and 4-bit counters) plus directed literal checks.
module tb_enc_8b10b_rd_sel;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic [9:0] i_minus = '0;
  logic [9:0] i_plus = '0;
  logic       i_k_error = 1'b0;
  logic       i_rd_reset = 1'b0;
  logic       i_cnt_clr = 1'b0;

  logic [9:0]  a_data, b_data;
  logic        a_valid, b_valid, a_rd, b_rd, a_de, b_de, a_ke, b_ke;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  enc_8b10b_rd_sel u_dut16 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_minus(i_minus), .i_plus(i_plus),
    .i_k_error(i_k_error), .i_rd_reset(i_rd_reset), .i_cnt_clr(i_cnt_clr),
    .o_data(a_data), .o_valid(a_valid), .o_rd(a_rd), .o_disp_error(a_de),
    .o_k_error(a_ke), .o_err_cnt(a_cnt)
  );

  enc_8b10b_rd_sel #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_minus(i_minus), .i_plus(i_plus),
    .i_k_error(i_k_error), .i_rd_reset(i_rd_reset), .i_cnt_clr(i_cnt_clr),
    .o_data(b_data), .o_valid(b_valid), .o_rd(b_rd), .o_disp_error(b_de),
    .o_k_error(b_ke), .o_err_cnt(b_cnt)
  );

  // Model: expected outputs derived directly from the disparity rules.
  logic [9:0] m_data;
  logic       m_valid, m_rd, m_de, m_ke;
  int         m_cnt16, m_cnt4;

  always @(posedge clk or negedge rst_n) begin
    logic eff;
    logic [9:0] sel;
    int w;
    bit err;
    if (!rst_n) begin
      m_data <= '0; m_valid <= 0; m_rd <= 0; m_de <= 0; m_ke <= 0;
      m_cnt16 <= 0; m_cnt4 <= 0;
    end else begin
      eff = i_rd_reset ? 1'b0 : m_rd;
      err = 0;
      m_valid <= i_valid;
      m_de <= 0;
      m_ke <= 0;
      m_rd <= eff;
      if (i_valid && i_k_error) begin
        m_data <= '0;
        m_ke <= 1;
        err = 1;
      end else if (i_valid) begin
        sel = eff ? i_plus : i_minus;
        w = $countones(sel);
        m_data <= sel;
        if (w == 5) m_rd <= eff;
        else if (w == 6 && eff == 0) m_rd <= 1;
        else if (w == 4 && eff == 1) m_rd <= 0;
        else begin m_de <= 1; err = 1; end
      end
      if (i_cnt_clr) begin
        m_cnt16 <= err ? 1 : 0;
        m_cnt4  <= err ? 1 : 0;
      end else if (err) begin
        m_cnt16 <= (m_cnt16 + 1 > 65535) ? 65535 : m_cnt16 + 1;
        m_cnt4  <= (m_cnt4 + 1 > 15) ? 15 : m_cnt4 + 1;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("data16",  a_data,  m_data);
    chk("valid16", a_valid, m_valid);
    chk("rd16",    a_rd,    m_rd);
    chk("de16",    a_de,    m_de);
    chk("ke16",    a_ke,    m_ke);
    chk("cnt16",   a_cnt,   m_cnt16);
    chk("data4",   b_data,  m_data);
    chk("valid4",  b_valid, m_valid);
    chk("rd4",     b_rd,    m_rd);
    chk("de4",     b_de,    m_de);
    chk("ke4",     b_ke,    m_ke);
    chk("cnt4",    b_cnt,   m_cnt4);
  end

  // Presents one cycle of inputs; returns #1 after the capturing edge.
  task automatic sym(input bit v, input logic [9:0] mn, input logic [9:0] pl,
                     input bit ke, input bit rr, input bit clr);
    i_valid = v; i_minus = mn; i_plus = pl; i_k_error = ke; i_rd_reset = rr; i_cnt_clr = clr;
    @(posedge clk);
    #1;
    i_valid = 0; i_k_error = 0; i_rd_reset = 0; i_cnt_clr = 0;
  endtask

  localparam logic [9:0] K_M = 10'h0FA;
  localparam logic [9:0] K_P = 10'h305;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_data", a_data, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_rd", a_rd, 0);
    chk("rst_cnt", a_cnt, 0);
    rst_n = 1;
    sym(0, '0, '0, 0, 0, 0);

    sym(1, K_M, K_P, 0, 0, 0);
    chk("k285_a_data", a_data, 10'h0FA);
    chk("k285_a_rd", a_rd, 1);
    sym(1, K_M, K_P, 0, 0, 0);
    chk("k285_b_data", a_data, 10'h305);
    chk("k285_b_rd", a_rd, 0);
    chk("k285_b_de", a_de, 0);

    sym(1, K_M, K_P, 0, 0, 0);
    sym(1, 10'h2AA, 10'h2AA, 0, 0, 0);
    chk("d215_data", a_data, 10'h2AA);
    chk("d215_rd", a_rd, 1);
    chk("d215_de", a_de, 0);

    sym(1, K_M, K_P, 0, 1, 0);
    chk("rdrst_data", a_data, 10'h0FA);
    chk("rdrst_rd", a_rd, 1);
    sym(0, 10'h155, 10'h155, 0, 0, 0);
    chk("gap_valid", a_valid, 0);
    chk("gap_hold", a_data, 10'h0FA);
    sym(0, '0, '0, 0, 1, 0);
    chk("idle_rdrst", a_rd, 0);

    sym(1, 10'h3FF, 10'h000, 0, 0, 0);
    chk("bad_de", a_de, 1);
    chk("bad_rd", a_rd, 0);
    chk("bad_cnt", a_cnt, 1);
    sym(1, 10'h0FA, 10'h305, 1, 0, 0);
    chk("kerr_data", a_data, 0);
    chk("kerr_ke", a_ke, 1);
    chk("kerr_cnt", a_cnt, 2);

    // RD+ with a weight-0 word, then a weight-6 word from RD+ are both errors.
    sym(1, K_M, K_P, 0, 0, 0);
    sym(1, 10'h3FF, 10'h000, 0, 0, 0);
    chk("w0_de", a_de, 1);
    sym(1, 10'h000, 10'h3F0, 0, 0, 0);
    chk("w6rdp_de", a_de, 1);
    chk("w6rdp_rd", a_rd, 1);

    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) sym(1, 10'h3FF, 10'h3FF, 0, 0, 0);
      else            sym(1, 10'h000, 10'h000, 1, 0, 0);
    end
    chk("sat4", b_cnt, 15);
    sym(1, 10'h3FF, 10'h3FF, 0, 0, 1);
    chk("clr_err4", b_cnt, 1);
    chk("clr_err16", a_cnt, 1);
    sym(1, K_M, K_P, 0, 1, 1);
    chk("clr_ok4", b_cnt, 0);

    sym(0, '0, '0, 0, 1, 0);
    sym(1, K_M, K_P, 0, 0, 0);
    chk("pre_rst_rd", a_rd, 1);
    i_valid = 1; i_minus = K_M; i_plus = K_P;
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_data", a_data, 0);
    chk("mid_rst_rd", a_rd, 0);
    chk("mid_rst_valid", a_valid, 0);
    chk("mid_rst_cnt", b_cnt, 0);
    i_valid = 0;
    @(posedge clk);
    #3;
    rst_n = 1;
    sym(1, K_M, K_P, 0, 0, 0);
    chk("post_rst_data", a_data, 10'h0FA);
    chk("post_rst_rd", a_rd, 1);

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
